// File: rtl/ra_pq_regarray.sv
// Register-array priority queue: sorted kv_t cells, minimum key at cell 0.
// Enqueue, dequeue and replace each complete in a single cycle.

package pq_pkg;
    parameter int unsigned KeyW = 8;
    parameter int unsigned ValW = 8;

    typedef struct packed {
        logic [KeyW-1:0] key;
        logic [ValW-1:0] value;
    } kv_t;
endpackage

module ra_pq_regarray
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  kv_t                        kvi,
    input  logic                       deq,
    output kv_t                        kvo,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    kv_t              r_q [DEPTH];
    kv_t              r_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             err_q, err_d;

    kv_t              r_prev [DEPTH];
    kv_t              r_next [DEPTH];
    logic [DEPTH-1:0] g, h, g_prev, h_prev;
    logic             is_empty, is_full;
    logic             do_enq, do_deq, do_rep;

    assign is_empty = ~v_q[0];
    assign is_full  = v_q[DEPTH-1];

    // enq+deq on an empty queue degrades to a plain enqueue (flagged as err).
    assign do_enq = enq & (deq ? is_empty : ~is_full);
    assign do_deq = deq & ~enq & ~is_empty;
    assign do_rep = deq & enq & ~is_empty;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            g[i] = ~v_q[i] | (kvi.key < r_q[i].key);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            h[i] = ~v_q[i+1] | (kvi.key < r_q[i+1].key);
        end
        h[DEPTH-1] = 1'b1;
        g_prev = {g[DEPTH-2:0], 1'b0};
        h_prev = {h[DEPTH-2:0], 1'b0};

        r_prev[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            r_prev[i] = r_q[i-1];
        end
        r_next[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            r_next[i] = r_q[i+1];
        end
    end

    always_comb begin
        r_d     = r_q;
        v_d     = v_q;
        count_d = count_q;
        err_d   = (enq & ~deq & is_full) | (deq & is_empty);

        if (do_enq) begin
            // Strict compare: a new item lands behind existing equal keys.
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] = g_prev[i] ? r_prev[i] : (g[i] ? kvi : r_q[i]);
            end
            v_d     = {v_q[DEPTH-2:0], 1'b1};
            count_d = count_q + CntW'(1);
        end else if (do_deq) begin
            r_d     = r_next;
            v_d     = {1'b0, v_q[DEPTH-1:1]};
            count_d = count_q - CntW'(1);
        end else if (do_rep) begin
            // Cells below the insertion point shift down over the removed head.
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] = h[i] ? (h_prev[i] ? r_q[i] : kvi) : r_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            v_q     <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            r_q     <= r_d;
            v_q     <= v_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign kvo   = r_q[0];
    assign empty = is_empty;
    assign full  = is_full;
    assign count = count_q;
    assign err   = err_q;

endmodule
